exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Commit-point exception/interrupt sequencer: arbitrates per-stage exception flags and pending interrupts.
//  Sits between the commit stage and csr; drives csr's is_exception/is_ertn inputs.
//  Issues pipeline flush and fetch redirect, then holds off commit until the flush window has elapsed.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles flush stays asserted after a trap or ertn (>=1)
// PORTS
//  clk               in   1    clock
//  rst               in   1    synchronous, active-high reset
//  commit_valid      in   1    instruction at commit this cycle
//  commit_pc         in   32   its pc
//  if_exc_valid      in   1    fetch-stage exception (ADEF/PIF/TLBR/PPI)
//  if_exc_cause      in   `ExceptionCauseWidth  fetch cause code
//  id_exc_valid      in   1    decode exception (INE/IPE/SYS/BRK)
//  id_exc_cause      in   `ExceptionCauseWidth  decode cause code
//  mem_exc_valid     in   1    memory exception (ALE/ADEM/PIL/PIS/PME/PPI/TLBR)
//  mem_exc_cause     in   `ExceptionCauseWidth  memory cause code
//  mem_bad_addr      in   32   faulting data address
//  commit_is_ertn    in   1    committing instruction is ertn
//  crmd_ie           in   1    CRMD.IE from csr
//  ecfg_lie          in   12   local interrupt enables from csr
//  estat_is          in   12   interrupt status from csr
//  eentry_va         in   32   exception entry from csr
//  tlbrentry_va      in   32   TLB-refill entry
//  era_pc            in   32   ERA from csr
//  is_exception      out  1    1-cycle pulse to csr
//  exception_cause   out  `ExceptionCauseWidth  to csr
//  exception_pc      out  32   to csr
//  exception_addr    out  32   to csr (BADV source)
//  is_syscall_break  out  1    to csr, valid with is_exception
//  is_ertn           out  1    1-cycle pulse to csr
//  flush             out  1    flush all pipeline stages
//  redirect_valid    out  1    1-cycle pulse, fetch loads redirect_pc
//  redirect_pc       out  32   trap/return target
//  commit_block      out  1    commit must not retire this cycle
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, int_pend_q=0. Reset mid-FLUSH aborts to IDLE immediately.
//  - int_pend_q <= crmd_ie & |(ecfg_lie & estat_is), registered every cycle (no comb path to csr).
//  - IDLE, commit_valid=1, pick by priority: int_pend_q > if_exc > id_exc > mem_exc > commit_is_ertn.
//  - Interrupt: cause=`EXCEPTION_INT, exception_pc=commit_pc, addr=0; instruction does not retire.
//  - if/id exception: addr=commit_pc. mem exception: addr=mem_bad_addr.
//  - is_syscall_break=1 only for SYS/BRK causes; csr adds 4 to ERA.
//  - Trap outputs (is_exception, cause, pc, addr, redirect_valid, redirect_pc) registered: asserted cycle N+1 for
//    commit at N. redirect_pc = tlbrentry_va if cause==`EXCEPTION_TLBR, else eentry_va.
//  - ertn (no higher event): is_ertn pulse and redirect_pc=era_pc (era_pc sampled at cycle N) at N+1.
//  - commit_block is combinational: 1 in IDLE whenever a trap/ertn/interrupt is selected this cycle, 1 throughout FLUSH.
//  - FSM: IDLE --trap|ertn--> FLUSH (cnt=FLUSH_CYCLES-1). FLUSH: flush=1, cnt-- per cycle, cnt==0 -> IDLE.
//    flush is registered with the pulses, so it first rises at N+1 and stays high FLUSH_CYCLES cycles.
//  - In FLUSH all commit inputs are ignored and int_pend_q cannot fire. Sampling resumes the cycle after return to IDLE.
//  - commit_valid=0: exception flags are ignored; a pending interrupt waits for the next valid commit.
//  - Pulses (is_exception/is_ertn/redirect_valid) are exactly 1 cycle; the cause/pc/addr regs hold their value until next trap.
// STRUCTURE
//  - Cause codes and `ExceptionCauseWidth come from define.v; the block adds no new encodings.
//  - One combinational sub-module exc_priority_sel: inputs int/if/id/mem/ertn, outputs sel_kind, cause, addr.
//  - Top level: int_pend_q reg, output regs, 2-state FSM plus flush counter ($clog2(FLUSH_CYCLES+1) bits).
// TESTING
//  - Commit pc=0x1c000100, id_exc SYS -> N+1: is_exception=1, cause=SYS, pc=0x1c000100, syscall_break=1,
//    redirect_pc=eentry_va(0x1c008000); flush high 2 cycles; commit_block=1 at N.
//  - if_exc ADEF and mem_exc ALE together at pc=0x8 -> cause=ADEF, addr=0x8; ALE dropped.
//  - crmd_ie=1, lie=0x800, is=0x800 (timer) with an ertn committing -> cause=INT, exception_pc=ertn pc, no is_ertn.
//  - crmd_ie=0 with the same lie/is -> no trap.
//  - ertn with era_pc=0x1c000204 -> is_ertn pulse, redirect_pc=0x1c000204, flush 2 cycles.
//  - mem TLBR at addr 0x40001000 -> redirect_pc=tlbrentry_va; exc in FLUSH ignored; rst at 2nd flush cycle -> flush=0 next cycle.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg
//   Shared types and constants for the commit-point exception sequencer.
//   Cause encodings mirror the core-wide exception code table (ecode field);
//   ADEF/ADEM share an ecode and are told apart by esubcode inside csr.
package exception_ctrl_pkg;

    localparam int ExceptionCauseWidth = 6;

    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_INT  = 6'h00;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_PIL  = 6'h01;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_PIS  = 6'h02;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_PIF  = 6'h03;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_PME  = 6'h04;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_PPI  = 6'h07;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_ADEF = 6'h08;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_ADEM = 6'h08;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_ALE  = 6'h09;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_SYS  = 6'h0b;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_BRK  = 6'h0c;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_INE  = 6'h0d;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_IPE  = 6'h0e;
    localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_TLBR = 6'h3f;

    // What the priority selector picked for the instruction at commit.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INT  = 2'd1,
        SEL_EXC  = 2'd2,
        SEL_ERTN = 2'd3
    } sel_kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // SYS/BRK make csr advance ERA past the trapping instruction.
    function automatic logic is_sys_brk(input logic [ExceptionCauseWidth-1:0] cause);
        return (cause == EXCEPTION_SYS) || (cause == EXCEPTION_BRK);
    endfunction

endpackage

// File: rtl/exception_ctrl_exc_priority_sel.sv
// exc_priority_sel
//   Purely combinational pick of the single event to act on at commit.
//   Order: pending interrupt > fetch exc > decode exc > memory exc > ertn.
// Ports
//   int_pend                    registered interrupt-pending flag
//   if/id/mem_exc_valid/_cause  per-stage exception flags and codes
//   mem_bad_addr, commit_pc     candidate BADV sources
//   commit_is_ertn              committing instruction is ertn
//   sel_kind, sel_cause, sel_addr  chosen event, its cause and BADV value
module exc_priority_sel
    import exception_ctrl_pkg::*;
(
    input  logic                           int_pend,
    input  logic                           if_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] if_exc_cause,
    input  logic                           id_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] id_exc_cause,
    input  logic                           mem_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] mem_exc_cause,
    input  logic [31:0]                    mem_bad_addr,
    input  logic [31:0]                    commit_pc,
    input  logic                           commit_is_ertn,
    output sel_kind_e                      sel_kind,
    output logic [ExceptionCauseWidth-1:0] sel_cause,
    output logic [31:0]                    sel_addr
);

    always_comb begin
        sel_kind  = SEL_NONE;
        sel_cause = '0;
        sel_addr  = '0;
        if (int_pend) begin
            sel_kind  = SEL_INT;
            sel_cause = EXCEPTION_INT;
        end else if (if_exc_valid) begin
            sel_kind  = SEL_EXC;
            sel_cause = if_exc_cause;
            sel_addr  = commit_pc;
        end else if (id_exc_valid) begin
            sel_kind  = SEL_EXC;
            sel_cause = id_exc_cause;
            sel_addr  = commit_pc;
        end else if (mem_exc_valid) begin
            sel_kind  = SEL_EXC;
            sel_cause = mem_exc_cause;
            sel_addr  = mem_bad_addr;
        end else if (commit_is_ertn) begin
            sel_kind  = SEL_ERTN;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl
//   Commit-point exception/interrupt sequencer. Picks one event per commit,
//   drives csr's trap/ertn pulses, flushes the pipe, redirects fetch and
//   holds off commit until the flush window is over.
// Ports
//   clk, rst (sync, active-high)
//   commit_*        instruction at commit (valid, pc, ertn)
//   *_exc_*         per-stage exception flags/codes, mem_bad_addr
//   crmd_ie, ecfg_lie, estat_is, eentry_va, tlbrentry_va, era_pc   from csr
//   is_exception, exception_cause/pc/addr, is_syscall_break, is_ertn   to csr
//   flush, redirect_valid, redirect_pc, commit_block   to pipeline
//
// state    | meaning
// ST_IDLE  | sampling commit; an event here moves to ST_FLUSH
// ST_FLUSH | flush asserted, commit ignored, cnt counts down to 0
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commit_valid,
    input  logic [31:0]                    commit_pc,
    input  logic                           if_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] if_exc_cause,
    input  logic                           id_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] id_exc_cause,
    input  logic                           mem_exc_valid,
    input  logic [ExceptionCauseWidth-1:0] mem_exc_cause,
    input  logic [31:0]                    mem_bad_addr,
    input  logic                           commit_is_ertn,
    input  logic                           crmd_ie,
    input  logic [11:0]                    ecfg_lie,
    input  logic [11:0]                    estat_is,
    input  logic [31:0]                    eentry_va,
    input  logic [31:0]                    tlbrentry_va,
    input  logic [31:0]                    era_pc,
    output logic                           is_exception,
    output logic [ExceptionCauseWidth-1:0] exception_cause,
    output logic [31:0]                    exception_pc,
    output logic [31:0]                    exception_addr,
    output logic                           is_syscall_break,
    output logic                           is_ertn,
    output logic                           flush,
    output logic                           redirect_valid,
    output logic [31:0]                    redirect_pc,
    output logic                           commit_block
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           int_pend_q, int_pend_d;
    logic                           is_exception_q, is_exception_d;
    logic                           is_ertn_q, is_ertn_d;
    logic                           redirect_valid_q, redirect_valid_d;
    logic [31:0]                    redirect_pc_q, redirect_pc_d;
    logic [ExceptionCauseWidth-1:0] cause_q, cause_d;
    logic [31:0]                    pc_q, pc_d;
    logic [31:0]                    addr_q, addr_d;
    logic                           sb_q, sb_d;

    sel_kind_e                      sel_kind;
    logic [ExceptionCauseWidth-1:0] sel_cause;
    logic [31:0]                    sel_addr;
    logic                           take;

    exc_priority_sel u_sel (
        .int_pend       (int_pend_q),
        .if_exc_valid   (if_exc_valid),
        .if_exc_cause   (if_exc_cause),
        .id_exc_valid   (id_exc_valid),
        .id_exc_cause   (id_exc_cause),
        .mem_exc_valid  (mem_exc_valid),
        .mem_exc_cause  (mem_exc_cause),
        .mem_bad_addr   (mem_bad_addr),
        .commit_pc      (commit_pc),
        .commit_is_ertn (commit_is_ertn),
        .sel_kind       (sel_kind),
        .sel_cause      (sel_cause),
        .sel_addr       (sel_addr)
    );

    always_comb begin
        // Interrupt request is registered so csr never sees a comb loop back.
        int_pend_d       = crmd_ie & (|(ecfg_lie & estat_is));
        take             = !rst && (state_q == ST_IDLE) && commit_valid && (sel_kind != SEL_NONE);
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_exception_d   = 1'b0;
        is_ertn_d        = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        addr_d           = addr_q;
        sb_d             = sb_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_LOAD;
                    redirect_valid_d = 1'b1;
                    if (sel_kind == SEL_ERTN) begin
                        is_ertn_d     = 1'b1;
                        redirect_pc_d = era_pc;
                    end else begin
                        is_exception_d = 1'b1;
                        cause_d        = sel_cause;
                        pc_d           = commit_pc;
                        addr_d         = sel_addr;
                        sb_d           = (sel_kind == SEL_EXC) && is_sys_brk(sel_cause);
                        redirect_pc_d  = (sel_cause == EXCEPTION_TLBR) ? tlbrentry_va : eentry_va;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            int_pend_q       <= 1'b0;
            is_exception_q   <= 1'b0;
            is_ertn_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cause_q          <= '0;
            pc_q             <= '0;
            addr_q           <= '0;
            sb_q             <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            int_pend_q       <= int_pend_d;
            is_exception_q   <= is_exception_d;
            is_ertn_q        <= is_ertn_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cause_q          <= cause_d;
            pc_q             <= pc_d;
            addr_q           <= addr_d;
            sb_q             <= sb_d;
        end
    end

    assign is_exception     = is_exception_q;
    assign exception_cause  = cause_q;
    assign exception_pc     = pc_q;
    assign exception_addr   = addr_q;
    assign is_syscall_break = sb_q;
    assign is_ertn          = is_ertn_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = (state_q == ST_FLUSH);
    // Comb so the trapping instruction itself is kept from retiring.
    assign commit_block     = !rst && (take || (state_q == ST_FLUSH));

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;
    import exception_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        if_exc_valid, id_exc_valid, mem_exc_valid;
    logic [5:0]  if_exc_cause, id_exc_cause, mem_exc_cause;
    logic [31:0] mem_bad_addr;
    logic        commit_is_ertn;
    logic        crmd_ie;
    logic [11:0] ecfg_lie, estat_is;
    logic [31:0] eentry_va, tlbrentry_va, era_pc;
    logic        is_exception, is_syscall_break, is_ertn, flush, redirect_valid, commit_block;
    logic [5:0]  exception_cause;
    logic [31:0] exception_pc, exception_addr, redirect_pc;

    exception_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .if_exc_valid(if_exc_valid), .if_exc_cause(if_exc_cause),
        .id_exc_valid(id_exc_valid), .id_exc_cause(id_exc_cause),
        .mem_exc_valid(mem_exc_valid), .mem_exc_cause(mem_exc_cause),
        .mem_bad_addr(mem_bad_addr), .commit_is_ertn(commit_is_ertn),
        .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_is(estat_is),
        .eentry_va(eentry_va), .tlbrentry_va(tlbrentry_va), .era_pc(era_pc),
        .is_exception(is_exception), .exception_cause(exception_cause),
        .exception_pc(exception_pc), .exception_addr(exception_addr),
        .is_syscall_break(is_syscall_break), .is_ertn(is_ertn), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit_block(commit_block)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining flush cycles plus the architectural results of
    // the last event, derived directly from the priority rules.
    int          m_busy;
    bit          m_int_pend, m_is_exc, m_is_ertn, m_rv, m_sb;
    logic [31:0] m_rpc, m_pc, m_addr;
    logic [5:0]  m_cause;

    always @(posedge clk) begin : model
        int          kind;   // 0 none, 1 trap, 2 ertn
        logic [5:0]  c;
        logic [31:0] a;
        if (rst) begin
            m_busy <= 0; m_int_pend <= 0; m_is_exc <= 0; m_is_ertn <= 0; m_rv <= 0;
            m_sb <= 0; m_rpc <= 0; m_pc <= 0; m_addr <= 0; m_cause <= 0;
        end else begin
            m_is_exc <= 0; m_is_ertn <= 0; m_rv <= 0;
            m_int_pend <= crmd_ie && ((ecfg_lie & estat_is) != 12'd0);
            kind = 0; c = 0; a = 0;
            if (m_busy > 0) m_busy <= m_busy - 1;
            else if (commit_valid) begin
                if (m_int_pend)          begin kind = 1; c = 6'h00;         a = 0;            end
                else if (if_exc_valid)   begin kind = 1; c = if_exc_cause;  a = commit_pc;    end
                else if (id_exc_valid)   begin kind = 1; c = id_exc_cause;  a = commit_pc;    end
                else if (mem_exc_valid)  begin kind = 1; c = mem_exc_cause; a = mem_bad_addr; end
                else if (commit_is_ertn) kind = 2;
            end
            if (kind != 0) begin
                m_busy <= FC;
                m_rv   <= 1;
            end
            if (kind == 1) begin
                m_is_exc <= 1; m_cause <= c; m_pc <= commit_pc; m_addr <= a;
                m_sb  <= !m_int_pend && (c == 6'h0b || c == 6'h0c);
                m_rpc <= (c == 6'h3f) ? tlbrentry_va : eentry_va;
            end else if (kind == 2) begin
                m_is_ertn <= 1; m_rpc <= era_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("commit_block", 32'(commit_block), 32'(!rst && (m_busy > 0 ||
                (commit_valid && (m_int_pend || if_exc_valid || id_exc_valid ||
                                  mem_exc_valid || commit_is_ertn)))));
            chk("flush", 32'(flush), 32'(m_busy > 0));
            chk("is_exception", 32'(is_exception), 32'(m_is_exc));
            chk("is_ertn", 32'(is_ertn), 32'(m_is_ertn));
            chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("exception_cause", 32'(exception_cause), 32'(m_cause));
            chk("exception_pc", exception_pc, m_pc);
            chk("exception_addr", exception_addr, m_addr);
            chk("is_syscall_break", 32'(is_syscall_break), 32'(m_sb));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        commit_valid = 0; if_exc_valid = 0; id_exc_valid = 0; mem_exc_valid = 0;
        commit_is_ertn = 0;
    endtask

    logic [5:0] causes [11] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08,
                                6'h09, 6'h0b, 6'h0c, 6'h0d, 6'h3f};

    initial begin
        rst = 1; clr();
        commit_pc = 0; if_exc_cause = 0; id_exc_cause = 0; mem_exc_cause = 0;
        mem_bad_addr = 0; crmd_ie = 0; ecfg_lie = 0; estat_is = 0;
        eentry_va = 32'h1c008000; tlbrentry_va = 32'h1c00f000; era_pc = 0;
        cyc(); chk_en = 1; cyc();
        at_neg();
        chk("rst_flush", 32'(flush), 0);
        chk("rst_is_exception", 32'(is_exception), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        cyc(); rst = 0;

        // SYS from decode
        commit_valid = 1; commit_pc = 32'h1c000100; id_exc_valid = 1; id_exc_cause = 6'h0b;
        at_neg(); chk("sys_commit_block_N", 32'(commit_block), 1);
        cyc(); clr(); at_neg();
        chk("sys_is_exception", 32'(is_exception), 1);
        chk("sys_cause", 32'(exception_cause), 32'h0b);
        chk("sys_pc", exception_pc, 32'h1c000100);
        chk("sys_sb", 32'(is_syscall_break), 1);
        chk("sys_redirect_pc", redirect_pc, 32'h1c008000);
        chk("sys_flush1", 32'(flush), 1);
        cyc(); at_neg();
        chk("sys_flush2", 32'(flush), 1);
        chk("sys_pulse_gone", 32'(is_exception), 0);
        cyc(); at_neg(); chk("sys_flush_end", 32'(flush), 0);

        // fetch ADEF beats memory ALE
        cyc();
        commit_valid = 1; commit_pc = 32'h8; if_exc_valid = 1; if_exc_cause = 6'h08;
        mem_exc_valid = 1; mem_exc_cause = 6'h09; mem_bad_addr = 32'h1234;
        cyc(); clr(); at_neg();
        chk("adef_cause", 32'(exception_cause), 32'h08);
        chk("adef_addr", exception_addr, 32'h8);
        chk("adef_sb", 32'(is_syscall_break), 0);
        cyc(); cyc(); cyc();

        // timer interrupt preempts an ertn
        crmd_ie = 1; ecfg_lie = 12'h800; estat_is = 12'h800;
        cyc();
        commit_valid = 1; commit_is_ertn = 1; commit_pc = 32'h1c000300; era_pc = 32'h1c000204;
        at_neg(); chk("int_commit_block", 32'(commit_block), 1);
        cyc(); clr(); crmd_ie = 0; at_neg();
        chk("int_is_exception", 32'(is_exception), 1);
        chk("int_cause", 32'(exception_cause), 0);
        chk("int_pc", exception_pc, 32'h1c000300);
        chk("int_no_ertn", 32'(is_ertn), 0);
        cyc(); cyc(); cyc();

        // interrupts disabled: plain commit retires
        commit_valid = 1; commit_pc = 32'h1c000400;
        at_neg(); chk("noint_commit_block", 32'(commit_block), 0);
        cyc(); clr(); at_neg();
        chk("noint_is_exception", 32'(is_exception), 0);
        ecfg_lie = 0; estat_is = 0;

        // ertn
        commit_valid = 1; commit_is_ertn = 1; commit_pc = 32'h1c000500;
        cyc(); clr(); at_neg();
        chk("ertn_pulse", 32'(is_ertn), 1);
        chk("ertn_redirect_valid", 32'(redirect_valid), 1);
        chk("ertn_redirect_pc", redirect_pc, 32'h1c000204);
        chk("ertn_flush1", 32'(flush), 1);
        cyc(); at_neg();
        chk("ertn_flush2", 32'(flush), 1);
        chk("ertn_pulse_gone", 32'(is_ertn), 0);
        cyc(); at_neg(); chk("ertn_flush_end", 32'(flush), 0);

        // memory TLBR, exception in flush ignored, reset in 2nd flush cycle
        cyc();
        commit_valid = 1; commit_pc = 32'h1c000600; mem_exc_valid = 1;
        mem_exc_cause = 6'h3f; mem_bad_addr = 32'h40001000;
        cyc(); clr();
        commit_valid = 1; id_exc_valid = 1; id_exc_cause = 6'h0d;
        at_neg();
        chk("tlbr_redirect_pc", redirect_pc, 32'h1c00f000);
        chk("tlbr_addr", exception_addr, 32'h40001000);
        cyc(); rst = 1; at_neg();
        chk("tlbr_flush2", 32'(flush), 1);
        chk("tlbr_flush_exc_ignored", 32'(is_exception), 0);
        cyc(); rst = 0; clr(); at_neg();
        chk("rst_aborts_flush", 32'(flush), 0);
        chk("rst_clears_cause", 32'(exception_cause), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst            = ($urandom_range(299) == 0);
            commit_valid   = $urandom_range(1);
            commit_pc      = $urandom & 32'hfffffffc;
            if_exc_valid   = ($urandom_range(7) == 0);
            id_exc_valid   = ($urandom_range(7) == 0);
            mem_exc_valid  = ($urandom_range(7) == 0);
            commit_is_ertn = ($urandom_range(5) == 0);
            if_exc_cause   = causes[$urandom_range(10)];
            id_exc_cause   = causes[$urandom_range(10)];
            mem_exc_cause  = causes[$urandom_range(10)];
            mem_bad_addr   = $urandom;
            crmd_ie        = $urandom_range(1);
            ecfg_lie       = 12'($urandom);
            estat_is       = ($urandom_range(9) == 0) ? 12'($urandom) : 12'd0;
            eentry_va      = $urandom;
            tlbrentry_va   = $urandom;
            era_pc         = $urandom;
        end
        cyc(); at_neg(); chk_en = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
